// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive path and its CRC-32 helper.
package eth_rx_pkg;

   localparam int          pMII_WIDTH   = 2;
   localparam logic [1:0]  cPRE_DIBIT   = 2'b01;
   localparam logic [1:0]  cSFD_DIBIT   = 2'b11;
   localparam logic [31:0] cCRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [31:0] cCRC_POLY    = 32'hEDB88320;

   typedef enum logic [2:0] {
      DROP,
      IDLE,
      PREAMBLE,
      DEST_ADDR,
      SRC_ADDR,
      LEN_TYPE,
      DATA
   } state_t;

   // One byte through the reflected CRC-32, LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ cCRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 register (init all ones, no final XOR).
module eth_crc32
   import eth_rx_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Init,
   input  logic        En,
   input  logic [7:0]  Data,
   output logic [31:0] Crc
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (Init) begin
         crc_d = '1;
      end else if (En) begin
         crc_d = crc32_byte(crc_q, Data);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         crc_q <= '1;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign Crc = crc_q;

endmodule

// File: rtl/eth_rx.sv
// RMII receive path: preamble/SFD detection, header extraction, FCS-stripped
// payload streaming and per-frame good/error reporting.
module eth_rx
   import eth_rx_pkg::*;
#(
   parameter int pMIN_FRAME_BYTES = 64,
   parameter int pMAX_FRAME_BYTES = 1518
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Rx_En,
   input  logic [pMII_WIDTH-1:0] Rx_Data,
   input  logic                  Crs_Dv,
   output logic [7:0]            Rx_Byte,
   output logic                  Rx_Byte_Vld,
   output logic                  Rx_Sof,
   output logic                  Rx_Eof,
   output logic                  Frame_Ok,
   output logic                  Frame_Err,
   output logic [47:0]           Dest_Addr,
   output logic [47:0]           Src_Addr,
   output logic [15:0]           Len_Type,
   output state_t                Dbg_State
);

   localparam int                cCNT_W  = $clog2(pMAX_FRAME_BYTES + 2);
   localparam logic [cCNT_W-1:0] cMAX_P1 = cCNT_W'(pMAX_FRAME_BYTES + 1);
   localparam logic [cCNT_W-1:0] cMIN    = cCNT_W'(pMIN_FRAME_BYTES);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [7:0]          shift_q, shift_d;
   logic [1:0]          pre_q, pre_d;
   logic [cCNT_W-1:0]   byte_cnt_q, byte_cnt_d, cnt_inc;
   logic [111:0]        hdr_q, hdr_d;
   logic [31:0]         dly_q, dly_d;
   logic [2:0]          fill_q, fill_d;
   logic                sof_pend_q, sof_pend_d;
   logic [7:0]          byte_q, byte_d;
   logic                vld_q, vld_d, sof_q, sof_d, eof_q, eof_d, ok_q, ok_d, err_q, err_d;
   logic [47:0]         dest_q, dest_d, src_q, src_d;
   logic [15:0]         len_q, len_d;
   logic [7:0]          new_byte;
   logic                crc_init, crc_en;
   logic [31:0]         crc;

   assign new_byte = {Rx_Data, shift_q[7:2]};
   assign cnt_inc  = (byte_cnt_q == cMAX_P1) ? byte_cnt_q : byte_cnt_q + 1'b1;

   eth_crc32 u_crc (
      .Clk  (Clk),
      .Rst  (Rst),
      .Init (crc_init),
      .En   (crc_en),
      .Data (new_byte),
      .Crc  (crc)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      pre_d      = pre_q;
      byte_cnt_d = byte_cnt_q;
      hdr_d      = hdr_q;
      dly_d      = dly_q;
      fill_d     = fill_q;
      sof_pend_d = sof_pend_q;
      byte_d     = byte_q;
      dest_d     = dest_q;
      src_d      = src_q;
      len_d      = len_q;
      vld_d      = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      crc_init   = 1'b0;
      crc_en     = 1'b0;

      case (state_q)
         DROP: begin
            if (!Crs_Dv) state_d = IDLE;
         end
         IDLE: begin
            crc_init = 1'b1;
            if (Crs_Dv && Rx_Data == cPRE_DIBIT) begin
               state_d = Rx_En ? PREAMBLE : DROP;
               pre_d   = 2'd1;
            end
         end
         PREAMBLE: begin
            crc_init = 1'b1;
            if (!Crs_Dv) begin
               state_d = DROP;
            end else if (Rx_Data == cPRE_DIBIT) begin
               pre_d = (pre_q == 2'd2) ? 2'd2 : pre_q + 2'd1;
            end else if (Rx_Data == cSFD_DIBIT && pre_q == 2'd2) begin
               state_d    = DEST_ADDR;
               cnt_d      = 2'd0;
               byte_cnt_d = '0;
               fill_d     = 3'd0;
               sof_pend_d = 1'b1;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            if (!Crs_Dv) begin
               eof_d   = 1'b1;
               state_d = IDLE;
               if (cnt_q != 2'd0 || byte_cnt_q < cMIN || crc != cCRC_RESIDUE) err_d = 1'b1;
               else                                                          ok_d  = 1'b1;
            end else begin
               shift_d = new_byte;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  crc_en     = 1'b1;
                  byte_cnt_d = cnt_inc;
                  if (cnt_inc == cMAX_P1) begin
                     state_d = DROP;
                     eof_d   = 1'b1;
                     err_d   = 1'b1;
                  end else if (state_q == DATA) begin
                     // Four-byte delay line holds back the FCS until the frame ends.
                     dly_d = {dly_q[23:0], new_byte};
                     if (fill_q == 3'd4) begin
                        byte_d     = dly_q[31:24];
                        vld_d      = 1'b1;
                        sof_d      = sof_pend_q;
                        sof_pend_d = 1'b0;
                     end else begin
                        fill_d = fill_q + 3'd1;
                     end
                  end else begin
                     hdr_d = {hdr_q[103:0], new_byte};
                     if (cnt_inc == cCNT_W'(6))  state_d = SRC_ADDR;
                     if (cnt_inc == cCNT_W'(12)) state_d = LEN_TYPE;
                     if (cnt_inc == cCNT_W'(14)) begin
                        state_d = DATA;
                        dest_d  = hdr_d[111:64];
                        src_d   = hdr_d[63:16];
                        len_d   = hdr_d[15:0];
                     end
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= DROP;
         cnt_q      <= '0;
         shift_q    <= '0;
         pre_q      <= '0;
         byte_cnt_q <= '0;
         hdr_q      <= '0;
         dly_q      <= '0;
         fill_q     <= '0;
         sof_pend_q <= 1'b0;
         byte_q     <= '0;
         vld_q      <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         dest_q     <= '0;
         src_q      <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         pre_q      <= pre_d;
         byte_cnt_q <= byte_cnt_d;
         hdr_q      <= hdr_d;
         dly_q      <= dly_d;
         fill_q     <= fill_d;
         sof_pend_q <= sof_pend_d;
         byte_q     <= byte_d;
         vld_q      <= vld_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
         dest_q     <= dest_d;
         src_q      <= src_d;
         len_q      <= len_d;
      end
   end

   assign Rx_Byte     = byte_q;
   assign Rx_Byte_Vld = vld_q;
   assign Rx_Sof      = sof_q;
   assign Rx_Eof      = eof_q;
   assign Frame_Ok    = ok_q;
   assign Frame_Err   = err_q;
   assign Dest_Addr   = dest_q;
   assign Src_Addr    = src_q;
   assign Len_Type    = len_q;
   assign Dbg_State   = state_q;

endmodule

// File: tb/tb_eth_rx.sv
// Bench for eth_rx: table-driven frames, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_eth_rx;
   import eth_rx_pkg::*;

   localparam int MIN_B = 64;
   localparam int MAX_B = 1518;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_en;
   logic [1:0]  rx_data;
   logic        crs_dv;
   logic [7:0]  rx_byte;
   logic        rx_byte_vld, rx_sof, rx_eof, frame_ok, frame_err;
   logic [47:0] dest_addr, src_addr;
   logic [15:0] len_type;
   state_t      dbg_state;

   eth_rx #(.pMIN_FRAME_BYTES(MIN_B), .pMAX_FRAME_BYTES(MAX_B)) dut (
      .Clk         (clk),
      .Rst         (rst),
      .Rx_En       (rx_en),
      .Rx_Data     (rx_data),
      .Crs_Dv      (crs_dv),
      .Rx_Byte     (rx_byte),
      .Rx_Byte_Vld (rx_byte_vld),
      .Rx_Sof      (rx_sof),
      .Rx_Eof      (rx_eof),
      .Frame_Ok    (frame_ok),
      .Frame_Err   (frame_err),
      .Dest_Addr   (dest_addr),
      .Src_Addr    (src_addr),
      .Len_Type    (len_type),
      .Dbg_State   (dbg_state)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic        ok;
      logic        err;
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] len;
   } eof_t;

   typedef struct {
      int   n_pay;
      int   corrupt_at;
      int   extra;
      logic exp_ok;
      int   exp_emit;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        mon_en   = 1'b0;
   logic [7:0]  exp_q[$];
   logic        exp_sof_q[$];
   eof_t        exp_eof_q[$];
   logic [7:0]  frame_q[$];
   logic [31:0] crc_tab[256];
   vec_t        vecs[9];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Scoreboard: every output byte and every end-of-frame pulse must be expected.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("eof_with_vld", 64'(rx_eof & rx_byte_vld), 64'd0);
         if (rx_byte_vld) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h expected none", rx_byte);
            end else begin
               chk("rx_byte", 64'(rx_byte), 64'(exp_q.pop_front()));
               chk("rx_sof", 64'(rx_sof), 64'(exp_sof_q.pop_front()));
            end
         end else begin
            chk("sof_without_vld", 64'(rx_sof), 64'd0);
         end
         if (rx_eof) begin
            if (exp_eof_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_eof: got ok=%0d err=%0d expected none", frame_ok, frame_err);
            end else begin
               eof_t e;
               e = exp_eof_q.pop_front();
               chk("frame_ok", 64'(frame_ok), 64'(e.ok));
               chk("frame_err", 64'(frame_err), 64'(e.err));
               chk("dest_addr", 64'(dest_addr), 64'(e.dest));
               chk("src_addr", 64'(src_addr), 64'(e.src));
               chk("len_type", 64'(len_type), 64'(e.len));
            end
         end else begin
            chk("ok_outside_eof", 64'(frame_ok), 64'd0);
            chk("err_outside_eof", 64'(frame_err), 64'd0);
         end
      end
   end

   function automatic logic [31:0] crc_of(input int last);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int j = 0; j <= last; j++) c = crc_tab[c[7:0] ^ frame_q[j]] ^ (c >> 8);
      return c;
   endfunction

   task automatic build_frame(input int n_pay, input logic rnd, input int corrupt_at,
                              input logic [7:0] cx, input logic [47:0] da,
                              input logic [47:0] sa, input logic [15:0] lt);
      logic [31:0] fcs;
      frame_q.delete();
      for (int j = 0; j < 6; j++) frame_q.push_back(da[47 - 8*j -: 8]);
      for (int j = 0; j < 6; j++) frame_q.push_back(sa[47 - 8*j -: 8]);
      frame_q.push_back(lt[15:8]);
      frame_q.push_back(lt[7:0]);
      for (int j = 0; j < n_pay; j++) frame_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(j));
      fcs = ~crc_of(frame_q.size() - 1);
      for (int j = 0; j < 4; j++) frame_q.push_back(fcs[8*j +: 8]);
      if (corrupt_at >= 0) frame_q[14 + corrupt_at] = frame_q[14 + corrupt_at] ^ cx;
   endtask

   task automatic expect_frame(input int n_emit, input logic ok, input logic with_eof);
      eof_t e;
      for (int j = 0; j < n_emit; j++) begin
         exp_q.push_back(frame_q[14 + j]);
         exp_sof_q.push_back(j == 0);
      end
      if (with_eof) begin
         e.ok   = ok;
         e.err  = !ok;
         e.dest = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
         e.src  = {frame_q[6], frame_q[7], frame_q[8], frame_q[9], frame_q[10], frame_q[11]};
         e.len  = {frame_q[12], frame_q[13]};
         exp_eof_q.push_back(e);
      end
   endtask

   task automatic drive(input logic dv, input logic [1:0] d, input int idx, input int rst_at);
      @(negedge clk);
      if (rst_at >= 0 && idx == rst_at + 1) begin
         chk("rst_byte_vld", 64'(rx_byte_vld), 64'd0);
         chk("rst_byte", 64'(rx_byte), 64'd0);
         chk("rst_eof", 64'(rx_eof), 64'd0);
         chk("rst_dest", 64'(dest_addr), 64'd0);
         chk("rst_len", 64'(len_type), 64'd0);
      end
      rst     = (rst_at >= 0 && idx >= rst_at && idx < rst_at + 2);
      crs_dv  = dv;
      rx_data = d;
   endtask

   task automatic send_frame(input int extra, input logic en, input int gap, input int rst_at);
      int         idx;
      logic [7:0] b;
      idx   = 0;
      rx_en = en;
      for (int p = 0; p < 31; p++) begin drive(1'b1, 2'b01, idx, rst_at); idx++; end
      drive(1'b1, 2'b11, idx, rst_at); idx++;
      for (int j = 0; j < frame_q.size(); j++) begin
         b = frame_q[j];
         for (int k = 0; k < 4; k++) begin drive(1'b1, b[2*k +: 2], idx, rst_at); idx++; end
      end
      for (int k = 0; k < extra; k++) begin drive(1'b1, 2'($urandom_range(0, 3)), idx, rst_at); idx++; end
      for (int g = 0; g < gap; g++) begin drive(1'b0, 2'b00, idx, rst_at); idx++; end
   endtask

   task automatic check_drained(input string name);
      chk(name, 64'(exp_q.size() + exp_eof_q.size()), 64'd0);
      exp_q.delete();
      exp_sof_q.delete();
      exp_eof_q.delete();
   endtask

   initial begin
      logic [31:0] c;
      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[i] = c;
      end

      vecs[0] = '{46,   -1, 0, 1'b1, 46};
      vecs[1] = '{46,   16, 0, 1'b0, 46};
      vecs[2] = '{42,   -1, 0, 1'b0, 42};
      vecs[3] = '{46,   -1, 2, 1'b0, 46};
      vecs[4] = '{0,    -1, 0, 1'b0, 0};
      vecs[5] = '{1,    -1, 0, 1'b0, 1};
      vecs[6] = '{45,   -1, 0, 1'b0, 45};
      vecs[7] = '{1500, -1, 0, 1'b1, 1500};
      vecs[8] = '{1501, -1, 0, 1'b0, 1500};

      // Clock/reset
      rst = 1'b1; rx_en = 1'b1; rx_data = 2'b00; crs_dv = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_vld", 64'(rx_byte_vld), 64'd0);
      chk("reset_sof", 64'(rx_sof), 64'd0);
      chk("reset_eof", 64'(rx_eof), 64'd0);
      chk("reset_ok_err", 64'({frame_ok, frame_err}), 64'd0);
      chk("reset_hdr", 64'(dest_addr | src_addr | 48'(len_type)), 64'd0);
      chk("reset_state", 64'(dbg_state), 64'(IDLE));
      mon_en = 1'b1;

      // Table-driven frames
      foreach (vecs[v]) begin
         build_frame(vecs[v].n_pay, 1'b0, vecs[v].corrupt_at, 8'h01,
                     48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
         expect_frame(vecs[v].exp_emit, vecs[v].exp_ok, 1'b1);
         send_frame(vecs[v].extra, 1'b1, 12, -1);
         check_drained("table_drain");
      end

      // Preamble broken by a 00 dibit, then an immediate good frame
      for (int p = 0; p < 6; p++) drive(1'b1, 2'b01, 0, -1);
      drive(1'b1, 2'b00, 0, -1);
      drive(1'b0, 2'b00, 0, -1);
      build_frame(46, 1'b0, -1, 8'h00, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
      expect_frame(46, 1'b1, 1'b1);
      send_frame(0, 1'b1, 12, -1);
      check_drained("preamble_err_drain");

      // Receive disabled: frame ignored, header fields hold
      build_frame(46, 1'b1, -1, 8'h00, 48'h0A0B0C0D0E0F, 48'h112233445566, 16'h1234);
      send_frame(0, 1'b0, 12, -1);
      chk("hdr_hold_dest", 64'(dest_addr), 64'hFFFFFFFFFFFF);
      check_drained("disabled_drain");

      // Reset after the 20th payload byte while carrier stays up
      build_frame(46, 1'b0, -1, 8'h00, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
      expect_frame(16, 1'b0, 1'b0);
      send_frame(0, 1'b1, 12, 168);
      check_drained("reset_mid_drain");
      build_frame(46, 1'b0, -1, 8'h00, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
      expect_frame(46, 1'b1, 1'b1);
      send_frame(0, 1'b1, 12, -1);
      check_drained("after_reset_drain");

      // Random frames against the frame-level model
      for (int f = 0; f < 25; f++) begin
         int          n_pay, c_at, extra, total, n_emit;
         logic        en, ok, crc_ok;
         logic [31:0] calc, sent;
         n_pay = $urandom_range(0, 80);
         c_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n_pay + 3) : -1;
         extra = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
         en    = ($urandom_range(0, 9) != 0);
         build_frame(n_pay, 1'b1, c_at, 8'($urandom_range(1, 255)),
                     {$urandom, $urandom_range(0, 65535)} , {$urandom, $urandom_range(0, 65535)},
                     16'($urandom_range(0, 65535)));
         total  = frame_q.size();
         calc   = ~crc_of(total - 5);
         sent   = {frame_q[total-1], frame_q[total-2], frame_q[total-3], frame_q[total-4]};
         crc_ok = (calc == sent);
         ok     = crc_ok && extra == 0 && total >= MIN_B && total <= MAX_B;
         n_emit = ((total > MAX_B) ? MAX_B : total) - 18;
         if (en) expect_frame(n_emit, ok, 1'b1);
         send_frame(extra, en, $urandom_range(1, 6), -1);
      end
      repeat (8) @(negedge clk);
      check_drained("random_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
